// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode, state and control-field encodings for the multicycle MIPS sequencer.
package mips_pkg;
    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_JMP   = 6'h02,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_FAULT
    } state_e;
    localparam logic [1:0] ALUOP_FUNCT = 2'b00;
    localparam logic [1:0] ALUOP_ADD   = 2'b01;
    localparam logic [1:0] ALUOP_SUB   = 2'b10;
    localparam logic [1:0] ALUOP_JMP   = 2'b11;
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;
    localparam logic [1:0] PCSRC_ALU   = 2'b00;
    localparam logic [1:0] PCSRC_OUT   = 2'b01;
    localparam logic [1:0] PCSRC_JUMP  = 2'b10;
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: shared instruction/data memory request/ready handshake.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_ready;
    logic IorD;
    logic MemWrite;
    modport master(output mem_req, IorD, MemWrite, input mem_ready);
    modport slave(input mem_req, IorD, MemWrite, output mem_ready);
endinterface

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts memory wait cycles; expired once MEM_TIMEOUT-1 waits have elapsed.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(MEM_TIMEOUT);
    logic [W-1:0] count;
    always_ff @(posedge clk) begin
        if (clr) count <= '0;
        else if (en) count <= count + W'(1);
    end
    assign expired = count == W'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS control FSM with memory wait timeout and retire tracking.
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int RETIRE_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          opcode,
    input  logic                zero,
    multicycle_ctrl_if.master   mem,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                Branch,
    output logic                pc_en,
    output logic [1:0]          PCSrc,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic                RegDst,
    output logic                MemToReg,
    output logic                RegWrite,
    output logic                instr_retired,
    output logic [RETIRE_W-1:0] retired_count,
    output logic                illegal_op,
    output logic                fault,
    output logic [3:0]          state_o
);
    state_e state, next;
    logic expired, mem_state;
    logic [RETIRE_W-1:0] count_q;
    assign mem_state = state inside {S_FETCH, S_MEMRD, S_MEMWR};
    // Completing or leaving an access restarts the count, so every entry sees zero.
    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk(clk),
        .clr(rst | !mem_state | mem.mem_ready),
        .en(mem_state),
        .expired(expired)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            count_q <= '0;
        end else begin
            state   <= next;
            count_q <= instr_retired ? count_q + RETIRE_W'(1) : count_q;
        end
    end
    assign retired_count = rst ? '0 : count_q;
    assign state_o = rst ? 4'd0 : state;
    always_comb begin
        next = state;
        mem.mem_req = 1'b0;
        mem.IorD = 1'b0;
        mem.MemWrite = 1'b0;
        IRWrite = 1'b0;
        PCWrite = 1'b0;
        Branch = 1'b0;
        PCSrc = PCSRC_ALU;
        ALUSrcA = 1'b0;
        ALUSrcB = SRCB_RT;
        ALUOp = ALUOP_FUNCT;
        RegDst = 1'b0;
        MemToReg = 1'b0;
        RegWrite = 1'b0;
        instr_retired = 1'b0;
        illegal_op = 1'b0;
        fault = 1'b0;
        if (!rst) case (state)
            S_FETCH: begin
                mem.mem_req = 1'b1;
                ALUSrcB = SRCB_4;
                ALUOp = ALUOP_ADD;
                IRWrite = mem.mem_ready;
                PCWrite = mem.mem_ready;
                next = mem.mem_ready ? S_DECODE : expired ? S_FAULT : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMMSH;
                ALUOp = ALUOP_ADD;
                case (opcode)
                    OP_LW, OP_SW: next = S_MEMADR;
                    OP_RTYPE:     next = S_EXEC;
                    OP_ADDI:      next = S_ADDIEX;
                    OP_BEQ:       next = S_BRANCH;
                    OP_JMP:       next = S_JUMP;
                    default: begin
                        next = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp = ALUOP_ADD;
                next = opcode == OP_SW ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem.mem_req = 1'b1;
                mem.IorD = 1'b1;
                next = mem.mem_ready ? S_MEMWB : expired ? S_FAULT : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
                instr_retired = 1'b1;
                next = S_FETCH;
            end
            S_MEMWR: begin
                mem.mem_req = 1'b1;
                mem.IorD = 1'b1;
                mem.MemWrite = 1'b1;
                instr_retired = mem.mem_ready;
                next = mem.mem_ready ? S_FETCH : expired ? S_FAULT : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                next = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst = 1'b1;
                instr_retired = 1'b1;
                next = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp = ALUOP_ADD;
                next = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                instr_retired = 1'b1;
                next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp = ALUOP_SUB;
                Branch = 1'b1;
                PCSrc = PCSRC_OUT;
                instr_retired = 1'b1;
                next = S_FETCH;
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                PCSrc = PCSRC_JUMP;
                ALUOp = ALUOP_JMP;
                instr_retired = 1'b1;
                next = S_FETCH;
            end
            default: fault = 1'b1;
        endcase
        pc_en = PCWrite | (Branch & zero);
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle sequencer for the MIPS datapath. It replaces the single-cycle opcode decoder with a Moore/Mealy FSM that steps each instruction through fetch, decode, execute, memory and writeback. It drives a shared instruction/data memory through a req/ready handshake, with a wait-timeout that triggers a sticky fault. It also reports retired instructions and illegal opcodes.

Parameters:
MEM_TIMEOUT, 16, max consecutive cycles a memory state waits for mem_ready before entering FAULT (>=2)
RETIRE_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
opcode  in  6  IR[31:26]; stable from the cycle after the fetch completes until the next fetch
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
IorD  out  1  0 = PC address, 1 = ALUOut address
MemWrite  out  1  write strobe, meaningful with mem_req
IRWrite  out  1  load IR
PCWrite  out  1  unconditional PC load
Branch  out  1  conditional PC load qualifier
pc_en  out  1  PCWrite | (Branch & zero)
PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
ALUSrcA  out  1  0 = PC, 1 = rs
ALUSrcB  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
ALUOp  out  2  00 = R-type funct, 01 = add, 10 = sub, 11 = jump
RegDst  out  1  0 = rt, 1 = rd
MemToReg  out  1  0 = ALUOut, 1 = MDR
RegWrite  out  1  register file write
instr_retired  out  1  1-cycle pulse on instruction completion
retired_count  out  RETIRE_W  retired instruction count
illegal_op  out  1  1-cycle pulse, unknown opcode in DECODE
fault  out  1  sticky memory-timeout fault
state_o  out  4  current state (debug)

Behaviour:
- Reset (sync): state = FETCH, retired_count = 0, fault = 0, wait counter = 0. While rst = 1, all outputs are forced to 0.
- Any strobe not listed for a state is 0. All outputs are combinational from state, plus mem_ready/zero/opcode where noted.
- FETCH: mem_req = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 01, PCSrc = 00.
  - IRWrite and PCWrite are asserted only in the cycle mem_ready = 1; that cycle goes to DECODE. Otherwise stay in FETCH.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 01. Next state by opcode:
  - 0x23 / 0x2B -> MEMADR
  - 0x00 -> EXEC
  - 0x08 -> ADDIEX
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - other -> FETCH with illegal_op = 1; no retire.
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 01. LW -> MEMRD, SW -> MEMWR.
- MEMRD: mem_req = 1, IorD = 1. mem_ready -> MEMWB.
- MEMWB: RegWrite = 1, RegDst = 0, MemToReg = 1, retire -> FETCH.
- MEMWR: mem_req = 1, IorD = 1, MemWrite = 1. mem_ready -> retire in that same cycle -> FETCH.
- EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 00 -> ALUWB.
- ALUWB: RegWrite = 1, RegDst = 1, MemToReg = 0, retire -> FETCH.
- ADDIEX: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 01 -> ADDIWB.
- ADDIWB: RegWrite = 1, RegDst = 0, MemToReg = 0, retire -> FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10, Branch = 1, PCSrc = 01, pc_en = zero, retire -> FETCH.
- JUMP: PCWrite = 1, PCSrc = 10, ALUOp = 11, retire -> FETCH.
- Latency with mem_ready tied to 1: R-type/ADDI = 4 cycles, LW = 5, SW = 4, BEQ/J = 3.
- Retire: instr_retired = 1 in the final cycle; retired_count += 1 on that edge, wrapping modulo 2^RETIRE_W.
- Wait counter: cleared on entry to any memory state (FETCH, MEMRD, MEMWR). Increments each cycle in a memory state with mem_ready = 0.
  - mem_ready = 1 in the cycle the count reaches MEM_TIMEOUT-1: ready wins, the access completes.
  - Count reaches MEM_TIMEOUT-1 with mem_ready = 0: next state = FAULT.
- FAULT: fault = 1, all strobes 0, mem_req = 0. Stays in FAULT until rst.
- rst mid-instruction: the pending access is abandoned, no retire, the count clears, the FSM restarts at FETCH.

Decomposition:
- mips_pkg holds the shared opcodes enum (RType, ADDI, LW, SW, BEQ, JMP), the state enum (logic [3:0]), and ALUOp/ALUSrcB/PCSrc encoding constants.
- Sub-module mem_wait_timer (clear, count-enable, expired output) holds the MEM_TIMEOUT counter.

Test Plan:
- Reset, then mem_ready = 1, opcode = 0x00 -> states FETCH, DECODE, EXEC, ALUWB; RegWrite = 1 and RegDst = 1 in cycle 4; retired_count = 1.
- LW (0x23) with mem_ready low for 3 cycles in MEMRD -> stays in MEMRD 4 cycles with IorD = 1; MEMWB has MemToReg = 1; total 8 cycles.
- BEQ (0x04) with zero = 1, then with zero = 0 -> pc_en = 1 / 0 in BRANCH; PCSrc = 01; retired_count +1 each.
- Opcode 0x3F -> illegal_op pulses in DECODE, returns to FETCH, retired_count unchanged.
- mem_ready held 0 in FETCH for 16 cycles -> FAULT, fault = 1, mem_req = 0 until rst; a sync rst returns to FETCH with fault = 0.
- RETIRE_W = 4, retire 17 JMP (0x02) instructions -> count wraps to 1; each JMP asserts PCWrite = 1 and PCSrc = 10.
